// File: rtl/axis_stream_splitter.sv
// AXI4-Stream 1:2 packet router: each whole packet goes to port A or B, chosen
// from S_tdest on its first beat or by per-packet round-robin.
module axis_stream_splitter #(
    parameter int DATA_W     = 8,
    parameter bit ROUTE_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              S_tvalid,
    input  logic              S_tlast,
    input  logic [DATA_W-1:0] S_tdata,
    input  logic              S_tdest,
    output logic              S_tready,
    output logic              A_tvalid,
    output logic              A_tlast,
    output logic [DATA_W-1:0] A_tdata,
    input  logic              A_tready,
    output logic              B_tvalid,
    output logic              B_tlast,
    output logic [DATA_W-1:0] B_tdata,
    input  logic              B_tready,
    output logic [15:0]       pkt_cnt_a,
    output logic [15:0]       pkt_cnt_b
);

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    state_t            state_reg;
    logic              rr_reg;
    logic              sel;
    logic              accept;
    logic [1:0]        out_ready;
    logic [1:0]        out_valid;
    logic [1:0]        out_last;
    logic [1:0]        free;
    logic [DATA_W-1:0] out_data [2];
    logic [15:0]       out_cnt  [2];

    // Destination of the beat currently on S; locked once a packet is under way.
    always_comb begin
        sel = 1'b0;
        case (state_reg)
            IDLE:    sel = ROUTE_MODE ? rr_reg : S_tdest;
            LOCK_A:  sel = 1'b0;
            LOCK_B:  sel = 1'b1;
            default: sel = 1'b0;
        endcase
    end

    assign out_ready = {B_tready, A_tready};
    assign S_tready  = free[sel];
    assign accept    = S_tvalid && S_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
        end else if (accept) begin
            case (state_reg)
                IDLE:    if (!S_tlast) state_reg <= sel ? LOCK_B : LOCK_A;
                LOCK_A,
                LOCK_B:  if (S_tlast) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (ROUTE_MODE && S_tlast)
                rr_reg <= ~rr_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              valid_reg;
            logic              last_reg;
            logic [DATA_W-1:0] data_reg;
            logic [15:0]       cnt_reg;
            logic              load;
            logic              hs;

            assign load = accept && (sel == 1'(gi));
            assign hs   = valid_reg && out_ready[gi];

            // A load on the handshake cycle replaces the drained beat directly.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    data_reg  <= '0;
                end else if (load) begin
                    valid_reg <= 1'b1;
                    last_reg  <= S_tlast;
                    data_reg  <= S_tdata;
                end else if (hs) begin
                    valid_reg <= 1'b0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt_reg <= 16'd0;
                else if (hs && last_reg)
                    cnt_reg <= cnt_reg + 16'd1;
            end

            assign free[gi]      = !valid_reg || out_ready[gi];
            assign out_valid[gi] = valid_reg;
            assign out_last[gi]  = last_reg;
            assign out_data[gi]  = data_reg;
            assign out_cnt[gi]   = cnt_reg;
        end
    endgenerate

    assign A_tvalid  = out_valid[0];
    assign A_tlast   = out_last[0];
    assign A_tdata   = out_data[0];
    assign B_tvalid  = out_valid[1];
    assign B_tlast   = out_last[1];
    assign B_tdata   = out_data[1];
    assign pkt_cnt_a = out_cnt[0];
    assign pkt_cnt_b = out_cnt[1];

endmodule

// File: tb/tb_axis_stream_splitter.sv
// Bench for axis_stream_splitter: tdest-routed and round-robin instances checked
// every cycle against a packet-level scoreboard, plus directed literal checks.
module tb_axis_stream_splitter;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Index m = instance (0: tdest routing, 1: round-robin); port index i = m*2 + p.
    logic          s_tvalid [2];
    logic          s_tlast  [2];
    logic          s_tdest  [2];
    logic [DW-1:0] s_tdata  [2];
    logic          s_tready [2];
    logic          o_tvalid [4];
    logic          o_tlast  [4];
    logic          o_tready [4];
    logic [DW-1:0] o_tdata  [4];
    logic [15:0]   o_cnt    [4];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            axis_stream_splitter #(.DATA_W(DW), .ROUTE_MODE(1'(gi))) u_dut (
                .clk      (clk),
                .reset    (reset),
                .S_tvalid (s_tvalid[gi]),
                .S_tlast  (s_tlast[gi]),
                .S_tdata  (s_tdata[gi]),
                .S_tdest  (s_tdest[gi]),
                .S_tready (s_tready[gi]),
                .A_tvalid (o_tvalid[gi*2]),
                .A_tlast  (o_tlast[gi*2]),
                .A_tdata  (o_tdata[gi*2]),
                .A_tready (o_tready[gi*2]),
                .B_tvalid (o_tvalid[gi*2+1]),
                .B_tlast  (o_tlast[gi*2+1]),
                .B_tdata  (o_tdata[gi*2+1]),
                .B_tready (o_tready[gi*2+1]),
                .pkt_cnt_a(o_cnt[gi*2]),
                .pkt_cnt_b(o_cnt[gi*2+1])
            );
        end
    endgenerate

    int   n_pass  = 0;
    int   n_total = 0;
    bit   quiet   = 1'b0;
    bit   rand_rdy = 1'b0;
    bit   rdy_force [4];

    // Scoreboard: expected beats per port, observed handshakes, packet state.
    logic [8:0]  q    [4][$];
    logic [8:0]  obs  [4][$];
    logic [15:0] m_cnt [4];
    logic [8:0]  pend  [4];
    bit          pend_v [4];
    bit          in_pkt [2];
    bit          dest   [2];
    bit          rr     [2];
    int          s0     [4];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++)
            o_tready[i] = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force[i];
    end

    always @(negedge clk) begin
        int  b;
        int  i;
        bit  sel;
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                m_cnt[k]  = 16'd0;
                pend_v[k] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                in_pkt[k] = 1'b0;
                dest[k]   = 1'b0;
                rr[k]     = 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                b = m * 2;
                for (int p = 0; p < 2; p++) begin
                    i = b + p;
                    if (pend_v[i]) begin
                        check(o_tvalid[i] && ({o_tlast[i], o_tdata[i]} == pend[i]), "latency",
                              32'({o_tvalid[i], o_tlast[i], o_tdata[i]}), 32'({1'b1, pend[i]}));
                        pend_v[i] = 1'b0;
                    end
                    check(o_cnt[i] == m_cnt[i], "pkt_cnt", 32'(o_cnt[i]), 32'(m_cnt[i]));
                    if (o_tvalid[i]) begin
                        if (q[i].size() == 0)
                            check(1'b0, "spurious_beat", 32'({o_tlast[i], o_tdata[i]}), 32'h0);
                        else
                            check({o_tlast[i], o_tdata[i]} == q[i][0], "out_beat",
                                  32'({o_tlast[i], o_tdata[i]}), 32'(q[i][0]));
                    end
                end
                sel = in_pkt[m] ? dest[m] : ((m == 1) ? rr[m] : s_tdest[m]);
                check(s_tready[m] == (!o_tvalid[b+sel] || o_tready[b+sel]), "s_tready",
                      32'(s_tready[m]), 32'(!o_tvalid[b+sel] || o_tready[b+sel]));
                for (int p = 0; p < 2; p++) begin
                    i = b + p;
                    if (o_tvalid[i] && o_tready[i]) begin
                        obs[i].push_back({o_tlast[i], o_tdata[i]});
                        if (!quiet)
                            $display("t=%0t dut%0d port %s data=%02h last=%0b", $time, m,
                                     (p == 0) ? "A" : "B", o_tdata[i], o_tlast[i]);
                        if (q[i].size() != 0) begin
                            if (q[i][0][8]) m_cnt[i] = m_cnt[i] + 16'd1;
                            void'(q[i].pop_front());
                        end
                    end
                end
                if (s_tvalid[m] && s_tready[m]) begin
                    q[b+sel].push_back({s_tlast[m], s_tdata[m]});
                    pend[b+sel]   = {s_tlast[m], s_tdata[m]};
                    pend_v[b+sel] = 1'b1;
                    if (!in_pkt[m] && !s_tlast[m]) begin
                        in_pkt[m] = 1'b1;
                        dest[m]   = sel;
                    end else if (s_tlast[m]) begin
                        in_pkt[m] = 1'b0;
                    end
                    if (m == 1 && s_tlast[m]) rr[m] = ~rr[m];
                end
            end
        end
    end

    task automatic beat(input int m, input logic [7:0] d, input bit last, input bit dst);
        int t = 0;
        s_tvalid[m] = 1'b1;
        s_tdata[m]  = d;
        s_tlast[m]  = last;
        s_tdest[m]  = dst;
        do begin
            @(negedge clk);
            t++;
        end while (!s_tready[m] && t < 500);
        if (!s_tready[m]) check(1'b0, "accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int m, input int n);
        s_tvalid[m] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        bit busy;
        do begin
            @(posedge clk);
            #1;
            t++;
            busy = 1'b0;
            for (int i = 0; i < 4; i++) busy |= o_tvalid[i];
        end while (busy && t < 300);
        if (busy) check(1'b0, "drain_timeout", 32'h1, 32'h0);
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) s0[i] = obs[i].size();
    endtask

    task automatic check_obs(input int i, input int k, input logic [8:0] exp, input string name);
        if (obs[i].size() <= s0[i] + k) check(1'b0, name, 32'hFFFF, 32'(exp));
        else check(obs[i][s0[i]+k] == exp, name, 32'(obs[i][s0[i]+k]), 32'(exp));
    endtask

    task automatic check_new(input int i, input int n, input string name);
        check(obs[i].size() - s0[i] == n, name, 32'(obs[i].size() - s0[i]), 32'(n));
    endtask

    initial begin
        int len;
        bit dst;
        for (int m = 0; m < 2; m++) begin
            s_tvalid[m] = 1'b0;
            s_tlast[m]  = 1'b0;
            s_tdest[m]  = 1'b0;
            s_tdata[m]  = '0;
        end
        for (int i = 0; i < 4; i++) rdy_force[i] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check(o_tvalid[i] == 1'b0, "reset_tvalid", 32'(o_tvalid[i]), 32'h0);
            check(o_cnt[i] == 16'd0, "reset_cnt", 32'(o_cnt[i]), 32'h0);
        end
        check(s_tready[0] == 1'b1, "reset_s_tready", 32'(s_tready[0]), 32'h1);
        @(posedge clk);
        #1;

        // 3-beat packet to B by tdest
        snap();
        beat(0, 8'h11, 1'b0, 1'b1);
        beat(0, 8'h22, 1'b0, 1'b1);
        beat(0, 8'h33, 1'b1, 1'b1);
        idle(0, 1);
        drain();
        check_new(1, 3, "t1_b_beats");
        check_obs(1, 0, 9'h011, "t1_b0");
        check_obs(1, 1, 9'h022, "t1_b1");
        check_obs(1, 2, 9'h133, "t1_b2");
        check_new(0, 0, "t1_a_beats");
        check(o_cnt[1] == 16'd1, "t1_cnt_b", 32'(o_cnt[1]), 32'h1);
        check(o_cnt[0] == 16'd0, "t1_cnt_a", 32'(o_cnt[0]), 32'h0);

        // tdest toggling mid-packet is ignored; next packet is routed afresh
        snap();
        beat(0, 8'h41, 1'b0, 1'b0);
        beat(0, 8'h42, 1'b0, 1'b1);
        beat(0, 8'h43, 1'b0, 1'b0);
        beat(0, 8'h44, 1'b1, 1'b1);
        beat(0, 8'h45, 1'b1, 1'b1);
        idle(0, 1);
        drain();
        check_new(0, 4, "t2_a_beats");
        check_obs(0, 3, 9'h144, "t2_a_last");
        check_new(1, 1, "t2_b_beats");
        check_obs(1, 0, 9'h145, "t2_b0");

        // Round-robin single-beat packets
        snap();
        for (int k = 0; k < 4; k++) beat(1, 8'hA0 + 8'(k), 1'b1, 1'b1);
        idle(1, 1);
        drain();
        check_obs(2, 0, 9'h1A0, "t3_a0");
        check_obs(2, 1, 9'h1A2, "t3_a1");
        check_obs(3, 0, 9'h1A1, "t3_b0");
        check_obs(3, 1, 9'h1A3, "t3_b1");
        check(o_cnt[2] == 16'd2, "t3_cnt_a", 32'(o_cnt[2]), 32'h2);
        check(o_cnt[3] == 16'd2, "t3_cnt_b", 32'(o_cnt[3]), 32'h2);

        // Backpressure on A mid-packet
        snap();
        rdy_force[0] = 1'b0;
        @(posedge clk);
        #1;
        beat(0, 8'h51, 1'b0, 1'b0);
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 8'h52;
        s_tlast[0]  = 1'b0;
        s_tdest[0]  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check(s_tready[0] == 1'b0, "t4_stall_tready", 32'(s_tready[0]), 32'h0);
            check(o_tvalid[0] && o_tdata[0] == 8'h51, "t4_stall_data", 32'(o_tdata[0]), 32'h51);
        end
        rdy_force[0] = 1'b1;
        beat(0, 8'h52, 1'b0, 1'b1);
        beat(0, 8'h53, 1'b1, 1'b0);
        beat(0, 8'h61, 1'b0, 1'b1);
        beat(0, 8'h62, 1'b1, 1'b0);
        idle(0, 1);
        drain();
        check_new(0, 3, "t4_a_beats");
        check_obs(0, 2, 9'h153, "t4_a_last");
        check_new(1, 2, "t4_b_beats");
        check_obs(1, 1, 9'h162, "t4_b_last");

        // Counter wrap on A
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 65535; k++) beat(0, 8'($urandom), 1'b1, 1'b0);
        idle(0, 1);
        drain();
        check(o_cnt[0] == 16'hFFFF, "t5_cnt_full", 32'(o_cnt[0]), 32'hFFFF);
        beat(0, 8'h77, 1'b1, 1'b0);
        idle(0, 1);
        drain();
        check(o_cnt[0] == 16'h0000, "t5_cnt_wrap", 32'(o_cnt[0]), 32'h0);
        quiet = 1'b0;

        // Reset in the middle of a packet on A
        beat(0, 8'h71, 1'b0, 1'b0);
        beat(0, 8'h72, 1'b0, 1'b0);
        s_tvalid[0] = 1'b0;
        reset = 1'b1;
        #1;
        check(o_tvalid[0] == 1'b0, "t6_reset_a_tvalid", 32'(o_tvalid[0]), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        snap();
        beat(0, 8'h81, 1'b0, 1'b1);
        beat(0, 8'h82, 1'b1, 1'b0);
        idle(0, 1);
        drain();
        check_new(1, 2, "t6_b_beats");
        check_obs(1, 0, 9'h081, "t6_b0");
        check_new(0, 0, "t6_a_beats");

        // Randomised traffic with random backpressure on both instances
        rand_rdy = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int pk = 0; pk < 150; pk++) begin
                len = $urandom_range(1, 5);
                dst = 1'($urandom_range(0, 1));
                for (int k = 0; k < len; k++)
                    beat(m, 8'($urandom), k == len - 1, (k == 0) ? dst : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle(m, $urandom_range(1, 3));
            end
            idle(m, 1);
        end
        rand_rdy = 1'b0;
        drain();
        for (int i = 0; i < 4; i++)
            check(q[i].size() == 0, "undelivered_beats", 32'(q[i].size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_stream_splitter.md
# axis_stream_splitter

Single-input, dual-output AXI4-Stream packet router: the fan-out counterpart of the team's 2:1 stream arbiter. It accepts packets on slave port S and delivers each whole packet, unsplit and in order, to master port A or B. The destination is chosen per packet, either from the sideband S_tdest or by alternating round-robin. It sits between a single producer and two consumer pipelines, with one registered output stage per port.

## Interface
- DATA_W, 8, width of tdata on all ports
- ROUTE_MODE, 0, 0 = route by S_tdest (0→A, 1→B); 1 = round-robin per packet starting at A, S_tdest ignored
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- S_tvalid  in  1  input beat valid
- S_tlast  in  1  last beat of input packet
- S_tdata  in  DATA_W  input data
- S_tdest  in  1  destination select; sampled only on the first beat of a packet
- S_tready  out  1  splitter can accept the current S beat
- A_tvalid / B_tvalid  out  1  output beat valid
- A_tlast / B_tlast  out  1  output last beat
- A_tdata / B_tdata  out  DATA_W  output data
- A_tready / B_tready  in  1  downstream ready
- pkt_cnt_a / pkt_cnt_b  out  16  packets completed on A / B

## Operation
- FSM states:
  - IDLE: between packets.
  - LOCK_A: mid-packet, routed to A.
  - LOCK_B: mid-packet, routed to B.
- Candidate destination `sel`:
  - In IDLE: S_tdest (ROUTE_MODE=0), or round-robin pointer `rr` (ROUTE_MODE=1).
  - In LOCK_x: x.
- Each output has a one-entry holding register: valid, last, data.
- Register x is "free" when x_tvalid=0 or x_tready=1.
- S_tready = free(sel). This is a combinational path from the selected x_tready. The unselected port's tready never affects S_tready.
- Accepted beat (S_tvalid & S_tready):
  - Loads the beat into register sel; sel_tvalid=1 next cycle.
- FSM transitions, evaluated on each accepted beat:
  - IDLE, tlast=0 → LOCK_sel.
  - IDLE, tlast=1 (single-beat packet) → stays IDLE.
  - LOCK_x, tlast=1 → IDLE.
- Round-robin pointer `rr` toggles on every accepted beat with S_tlast=1, in ROUTE_MODE=1 only.
- Holding registers:
  - Handshake on x (x_tvalid & x_tready) with no new load clears x_tvalid.
  - Simultaneous handshake and load replaces the contents; x_tvalid stays 1.
- Ports run independently. A packet may begin on B while A still holds the final beat of the previous packet, and vice versa.
- Counters: pkt_cnt_x increments on each output handshake with x_tlast=1. Counts are 16-bit and wrap 0xFFFF→0x0000.
- Unselected output: holds its contents unchanged. No beat is ever duplicated to both ports.
- S_tdest changing mid-packet has no effect.

## Timing
- Reset values (asynchronous, immediate):
  - A/B_tvalid, A/B_tlast, A/B_tdata = 0.
  - pkt_cnt_a/b = 0.
  - FSM = IDLE, rr = A (0).
  - S_tready then follows free(sel): 1 after reset.
- Reset mid-packet: held beats are discarded, the FSM returns to IDLE, and the next S beat is treated as a first beat.
- Latency: a beat accepted at edge n is valid on the output after edge n.
- Throughput: 1 beat/cycle sustained while the destination tready=1.
- Destination backpressure (tready=0 while holding) drops S_tready in the same cycle. Held data/last stay stable until the handshake, per AXI4-Stream.
- Output valid never depends combinationally on tready.
- Counters update on the edge that completes the tlast handshake.

## Test plan
- Reset, then in ROUTE_MODE=0 send 3-beat packet {0x11,0x22,0x33} with tdest=1, both treadys=1 -> B emits 0x11,0x22,0x33 one cycle behind S, tlast on 0x33. A_tvalid stays 0. pkt_cnt_b=1, pkt_cnt_a=0.
- In ROUTE_MODE=0, toggle S_tdest every beat mid-packet on a 4-beat packet with initial tdest=0 -> all 4 beats on A. State returns to IDLE after tlast.
- In ROUTE_MODE=1, send four single-beat packets 0xA0..0xA3 -> destinations A,B,A,B. pkt_cnt_a=2, pkt_cnt_b=2.
- Hold A_tready=0 for 5 cycles mid-packet on A -> S_tready=0 from the cycle A fills. A_tdata is frozen. No beat is lost or duplicated after release. B is unaffected and accepts a following tdest=1 packet once A's packet ends.
- Preload pkt_cnt_a to 0xFFFF via 65535 single-beat packets, send one more to A -> pkt_cnt_a=0x0000.
- Assert reset for 1 cycle during beat 2 of a 4-beat packet on A -> A_tvalid=0 immediately. The next packet with tdest=1 is routed to B from its first beat.
